ldst_control_sequencer: RTL and testbench
=========================================

# ldst_control_sequencer

Hardwired control-step sequencer for the memory-class instructions (ld, ldi, st) of the datapath. It drives the bus, register-select and memory strobes step by step (T0–T7) in place of hand-sequenced stimulus. It generalises the fixed single-cycle memory step to a parametrised RAM latency and adds a store path, an illegal-opcode exit, run/idle control and a retired-instruction counter. It sits between the IR opcode field and the datapath control inputs.

## Interface
- MEM_LAT, 1: extra wait cycles per RAM access, 0..15
- OPC_W, 5: opcode field width
- CNT_W, 16: retired-instruction counter width
- ALU_W, 12: ALUControl width
- clk  in  1  system clock, rising edge
- clr  in  1  reset; asynchronous, active-high
- run  in  1  enable fetching; sampled only in IDLE and on entry to T0
- opcode  in  OPC_W  IR[31:27], valid from T3 onward
- PCout, MARin, IncPC, Zin, PCin, Zlowout, MDRRead, MDRin, MDRout, IRin  out  1 each  datapath strobes
- Gra, Grb, Rin_in, Rout_in, BAout, Yin, Cout, RAMwrite  out  1 each  select-logic and memory strobes
- ALUControl  out  ALU_W  ALU op; 12'h001 (ADD) in T4, else 0
- instr_done  out  1  one-cycle pulse in the final step of a legal instruction
- illegal  out  1  one-cycle pulse in T3 on an unsupported opcode
- retired  out  CNT_W  count of completed legal instructions, wraps

## Operation
- States: IDLE, T0, T1, T1W, T2, T3, T4, T5, T6, T6W, T7.
- IDLE: all strobes 0; go to T0 when run=1.
- T0: PCout, MARin, IncPC, Zin.
- T1: Zlowout, PCin, MDRRead. If MEM_LAT=0 also MDRin and go to T2; else go to T1W.
- T1W: MDRRead held for MEM_LAT cycles; MDRin only in the last of them; then T2.
- T2: MDRout, IRin.
- T3: Grb, BAout, Yin. Opcode decoded here: ld=5'b00000, ldi=5'b00001, st=5'b00010. Any other value: illegal=1, Yin suppressed, next state T0 if run=1 else IDLE.
- T4: Cout, ALUControl=ADD, Zin.
- T5: ld/st: Zlowout, MARin. ldi: Zlowout, Gra, Rin_in, instr_done; ldi ends here.
- T6: ld: MDRRead, and MDRin if MEM_LAT=0, else go to T6W, which follows the T1W rules. st: Gra, Rout_in, MDRin with MDRRead=0 (bus source).
- T7: ld: MDRout, Gra, Rin_in, instr_done. st: RAMwrite held 1+MEM_LAT cycles; instr_done only in the last cycle.
- After the final step: go to T0 if run=1, else IDLE.
- retired increments on every instr_done cycle and wraps from 2^CNT_W−1 to 0. An illegal opcode does not count.
- Opcode is latched at T3 into an internal register. Later changes on the opcode input are ignored until the next T3.

## Timing
- State, wait counter, latched opcode and retired are registered. Every strobe is a Moore decode of the registered state and counter, with no input-to-output path.
- Reset: on assertion of clr, state=IDLE, wait counter=0 and retired=0 immediately. Every output is 0 while clr=1, including in mid-instruction. First T0 is the first edge after release with run=1.
- Cycles from T0 to instr_done inclusive:
  - ld: 8+2·MEM_LAT
  - st: 8+2·MEM_LAT
  - ldi: 6+MEM_LAT
  - illegal: 4+MEM_LAT
- Back-to-back: T0 directly follows a final step with no bubble when run=1.
- The wait counter loads MEM_LAT−1 on entry to a wait state and counts down. It exits at 0. MEM_LAT=0 skips T1W and T6W entirely.
- run deasserted mid-instruction has no effect until the instruction finishes.

## Structure
- Package ctrl_pkg holds:
  - the state enum
  - opcode constants OPC_LD, OPC_LDI, OPC_ST
  - constant ALU_ADD = 12'h001
  - a control-bundle struct, shared with the later full control unit
- Sub-module mem_wait_counter: a loadable down-counter with a zero flag. It is instantiated once and shared by T1W, T6W and the st T7 hold.
- The output decode is one combinational block over the state, the latched opcode and the zero flag.

## Test plan
- MEM_LAT=1, run=1, opcode=ld:
  - T0..T7 strobes in order, with MDRin only in the second read cycle.
  - Gra/Rin_in/MDRout together in cycle 10; instr_done in cycle 10; retired=1.
- MEM_LAT=0, ld then st back-to-back:
  - Each takes 8 cycles, and T0 of st immediately follows ld's T7.
  - st T6 has MDRin=1 with MDRRead=0.
  - RAMwrite is high for exactly 1 cycle; retired=2.
- MEM_LAT=2, opcode=ldi:
  - instr_done in cycle 8 with Gra/Rin_in/Zlowout.
  - MARin is never asserted after T0.
- opcode=5'b10101:
  - illegal pulses in T3 and Yin=0 in that cycle.
  - Next cycle is T0; retired is unchanged.
- clr pulsed asynchronously in T4 (between edges):
  - All outputs go to 0 immediately; retired=0; state is IDLE.
  - Restart on run=1 begins at T0.
- CNT_W=4: 16 ldi instructions -> retired wraps from 15 to 0 on the 16th instr_done.

Source files
------------

// File: rtl/ldst_control_sequencer_pkg.sv
// ============================================================================
// Module   : ctrl_pkg
// Brief    : Shared states, opcodes and control bundle for the ld/ldi/st
//            control-step sequencer and the later full control unit.
// Revision : 1.0
// ============================================================================
`default_nettype none

package ctrl_pkg;

  localparam int WAIT_W = 4;

  typedef logic [3:0] state_t;

  localparam state_t ST_IDLE = 4'd0;
  localparam state_t ST_T0   = 4'd1;
  localparam state_t ST_T1   = 4'd2;
  localparam state_t ST_T1W  = 4'd3;
  localparam state_t ST_T2   = 4'd4;
  localparam state_t ST_T3   = 4'd5;
  localparam state_t ST_T4   = 4'd6;
  localparam state_t ST_T5   = 4'd7;
  localparam state_t ST_T6   = 4'd8;
  localparam state_t ST_T6W  = 4'd9;
  localparam state_t ST_T7   = 4'd10;

  localparam logic [4:0] OPC_LD  = 5'b00000;
  localparam logic [4:0] OPC_LDI = 5'b00001;
  localparam logic [4:0] OPC_ST  = 5'b00010;

  localparam logic [11:0] ALU_ADD = 12'h001;

  typedef struct packed {
    logic PCout;
    logic MARin;
    logic IncPC;
    logic Zin;
    logic PCin;
    logic Zlowout;
    logic MDRRead;
    logic MDRin;
    logic MDRout;
    logic IRin;
    logic Gra;
    logic Grb;
    logic Rin_in;
    logic Rout_in;
    logic BAout;
    logic Yin;
    logic Cout;
    logic RAMwrite;
    logic instr_done;
    logic illegal;
  } ctrl_t;

endpackage

`default_nettype wire

// File: rtl/ldst_control_sequencer_mem_wait_counter.sv
// ============================================================================
// Module   : mem_wait_counter
// Brief    : Loadable down-counter with zero flag, shared by all RAM waits.
// Revision : 1.0
// ============================================================================
`default_nettype none

module mem_wait_counter #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         clr,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         dec_i,
  output logic         zero_o
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule

`default_nettype wire

// File: rtl/ldst_control_sequencer.sv
// ============================================================================
// Module   : ldst_control_sequencer
// Brief    : Hardwired T0..T7 control-step sequencer for ld, ldi and st.
// Revision : 1.0
// ============================================================================
`default_nettype none

module ldst_control_sequencer
  import ctrl_pkg::*;
#(
  parameter int MEM_LAT = 1,
  parameter int OPC_W   = 5,
  parameter int CNT_W   = 16,
  parameter int ALU_W   = 12
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             run,
  input  logic [OPC_W-1:0] opcode,
  output logic             PCout,
  output logic             MARin,
  output logic             IncPC,
  output logic             Zin,
  output logic             PCin,
  output logic             Zlowout,
  output logic             MDRRead,
  output logic             MDRin,
  output logic             MDRout,
  output logic             IRin,
  output logic             Gra,
  output logic             Grb,
  output logic             Rin_in,
  output logic             Rout_in,
  output logic             BAout,
  output logic             Yin,
  output logic             Cout,
  output logic             RAMwrite,
  output logic [ALU_W-1:0] ALUControl,
  output logic             instr_done,
  output logic             illegal,
  output logic [CNT_W-1:0] retired
);

  localparam logic              C_NO_WAIT = (MEM_LAT == 0);
  localparam logic [WAIT_W-1:0] C_LAT_M1  = (MEM_LAT > 0) ? WAIT_W'(MEM_LAT - 1) : '0;
  localparam logic [WAIT_W-1:0] C_LAT     = WAIT_W'(MEM_LAT);
  localparam logic [OPC_W-1:0]  C_OPC_LD  = OPC_W'(OPC_LD);
  localparam logic [OPC_W-1:0]  C_OPC_LDI = OPC_W'(OPC_LDI);
  localparam logic [OPC_W-1:0]  C_OPC_ST  = OPC_W'(OPC_ST);
  localparam logic [ALU_W-1:0]  C_ALU_ADD = ALU_W'(ALU_ADD);

  state_t             state_q, state_d;
  logic [OPC_W-1:0]   opc_q, opc_d;
  logic [CNT_W-1:0]   retired_q, retired_d;

  logic               cnt_load;
  logic [WAIT_W-1:0]  cnt_load_val;
  logic               cnt_dec;
  logic               cnt_zero;

  logic               is_ld, is_ldi, is_st, is_legal;
  ctrl_t              ctrl;
  logic [ALU_W-1:0]   alu;

  assign is_ld    = (opc_q == C_OPC_LD);
  assign is_ldi   = (opc_q == C_OPC_LDI);
  assign is_st    = (opc_q == C_OPC_ST);
  assign is_legal = is_ld | is_ldi | is_st;

  mem_wait_counter #(
    .W (WAIT_W)
  ) u_wait (
    .clk        (clk),
    .clr        (clr),
    .load_i     (cnt_load),
    .load_val_i (cnt_load_val),
    .dec_i      (cnt_dec),
    .zero_o     (cnt_zero)
  );

  // Opcode is captured on the T2->T3 edge so T3 decode stays a pure Moore output.
  always_comb begin
    state_d      = state_q;
    opc_d        = opc_q;
    cnt_load     = 1'b0;
    cnt_load_val = '0;
    cnt_dec      = 1'b0;
    case (state_q)
      ST_IDLE: if (run) state_d = ST_T0;
      ST_T0:   state_d = ST_T1;
      ST_T1: begin
        if (C_NO_WAIT) begin
          state_d = ST_T2;
        end else begin
          state_d      = ST_T1W;
          cnt_load     = 1'b1;
          cnt_load_val = C_LAT_M1;
        end
      end
      ST_T1W: begin
        cnt_dec = 1'b1;
        if (cnt_zero) state_d = ST_T2;
      end
      ST_T2: begin
        state_d = ST_T3;
        opc_d   = opcode;
      end
      ST_T3:   state_d = is_legal ? ST_T4 : (run ? ST_T0 : ST_IDLE);
      ST_T4:   state_d = ST_T5;
      ST_T5:   state_d = is_ldi ? (run ? ST_T0 : ST_IDLE) : ST_T6;
      ST_T6: begin
        if (is_ld && !C_NO_WAIT) begin
          state_d      = ST_T6W;
          cnt_load     = 1'b1;
          cnt_load_val = C_LAT_M1;
        end else begin
          state_d      = ST_T7;
          cnt_load     = is_st;
          cnt_load_val = C_LAT;
        end
      end
      ST_T6W: begin
        cnt_dec = 1'b1;
        if (cnt_zero) state_d = ST_T7;
      end
      ST_T7: begin
        cnt_dec = 1'b1;
        if (is_ld || cnt_zero) state_d = run ? ST_T0 : ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    ctrl = '0;
    alu  = '0;
    case (state_q)
      ST_T0: begin
        ctrl.PCout = 1'b1;
        ctrl.MARin = 1'b1;
        ctrl.IncPC = 1'b1;
        ctrl.Zin   = 1'b1;
      end
      ST_T1: begin
        ctrl.Zlowout = 1'b1;
        ctrl.PCin    = 1'b1;
        ctrl.MDRRead = 1'b1;
        ctrl.MDRin   = C_NO_WAIT;
      end
      ST_T1W, ST_T6W: begin
        ctrl.MDRRead = 1'b1;
        ctrl.MDRin   = cnt_zero;
      end
      ST_T2: begin
        ctrl.MDRout = 1'b1;
        ctrl.IRin   = 1'b1;
      end
      ST_T3: begin
        ctrl.Grb     = 1'b1;
        ctrl.BAout   = 1'b1;
        ctrl.Yin     = is_legal;
        ctrl.illegal = ~is_legal;
      end
      ST_T4: begin
        ctrl.Cout = 1'b1;
        ctrl.Zin  = 1'b1;
        alu       = C_ALU_ADD;
      end
      ST_T5: begin
        ctrl.Zlowout    = 1'b1;
        ctrl.MARin      = ~is_ldi;
        ctrl.Gra        = is_ldi;
        ctrl.Rin_in     = is_ldi;
        ctrl.instr_done = is_ldi;
      end
      ST_T6: begin
        ctrl.MDRRead = is_ld;
        ctrl.MDRin   = is_st | C_NO_WAIT;
        ctrl.Gra     = is_st;
        ctrl.Rout_in = is_st;
      end
      ST_T7: begin
        ctrl.MDRout     = is_ld;
        ctrl.Gra        = is_ld;
        ctrl.Rin_in     = is_ld;
        ctrl.RAMwrite   = is_st;
        ctrl.instr_done = is_ld | cnt_zero;
      end
      default: ctrl = '0;
    endcase
  end

  assign retired_d = retired_q + {{(CNT_W-1){1'b0}}, ctrl.instr_done};

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q   <= ST_IDLE;
      opc_q     <= '0;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      opc_q     <= opc_d;
      retired_q <= retired_d;
    end
  end

  assign PCout      = ctrl.PCout;
  assign MARin      = ctrl.MARin;
  assign IncPC      = ctrl.IncPC;
  assign Zin        = ctrl.Zin;
  assign PCin       = ctrl.PCin;
  assign Zlowout    = ctrl.Zlowout;
  assign MDRRead    = ctrl.MDRRead;
  assign MDRin      = ctrl.MDRin;
  assign MDRout     = ctrl.MDRout;
  assign IRin       = ctrl.IRin;
  assign Gra        = ctrl.Gra;
  assign Grb        = ctrl.Grb;
  assign Rin_in     = ctrl.Rin_in;
  assign Rout_in    = ctrl.Rout_in;
  assign BAout      = ctrl.BAout;
  assign Yin        = ctrl.Yin;
  assign Cout       = ctrl.Cout;
  assign RAMwrite   = ctrl.RAMwrite;
  assign instr_done = ctrl.instr_done;
  assign illegal    = ctrl.illegal;
  assign ALUControl = alu;
  assign retired    = retired_q;

endmodule

`default_nettype wire

// File: tb/tb_ldst_control_sequencer.sv
// ============================================================================
// Module   : tb_ldst_control_sequencer
// Brief    : Scoreboard bench for three sequencer instances (MEM_LAT 1/0/2).
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_ldst_control_sequencer;

  localparam int N = 3;

  localparam logic [4:0] LD  = 5'b00000;
  localparam logic [4:0] LDI = 5'b00001;
  localparam logic [4:0] ST  = 5'b00010;

  localparam logic [19:0] M_PCOUT = 20'h00001;
  localparam logic [19:0] M_MARIN = 20'h00002;
  localparam logic [19:0] M_INCPC = 20'h00004;
  localparam logic [19:0] M_ZIN   = 20'h00008;
  localparam logic [19:0] M_PCIN  = 20'h00010;
  localparam logic [19:0] M_ZLO   = 20'h00020;
  localparam logic [19:0] M_RD    = 20'h00040;
  localparam logic [19:0] M_MDRIN = 20'h00080;
  localparam logic [19:0] M_MDRO  = 20'h00100;
  localparam logic [19:0] M_IRIN  = 20'h00200;
  localparam logic [19:0] M_GRA   = 20'h00400;
  localparam logic [19:0] M_GRB   = 20'h00800;
  localparam logic [19:0] M_RIN   = 20'h01000;
  localparam logic [19:0] M_ROUT  = 20'h02000;
  localparam logic [19:0] M_BAO   = 20'h04000;
  localparam logic [19:0] M_YIN   = 20'h08000;
  localparam logic [19:0] M_COUT  = 20'h10000;
  localparam logic [19:0] M_RAMW  = 20'h20000;
  localparam logic [19:0] M_DONE  = 20'h40000;
  localparam logic [19:0] M_ILL   = 20'h80000;

  logic        clk = 1'b0;
  logic        clr [N];
  logic        run [N];
  logic [4:0]  opc [N];
  logic [31:0] obs [N];
  logic [15:0] ret [N];

  logic [31:0] sb [$];
  int          exp_ret [N];
  int          errors = 0;
  int          checks = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < N; g++) begin : g_dut
    localparam int LAT = (g == 0) ? 1 : ((g == 1) ? 0 : 2);
    localparam int CW  = (g == 1) ? 4 : 16;
    logic [CW-1:0] r;
    logic [11:0]   alu;
    logic [19:0]   s;

    ldst_control_sequencer #(
      .MEM_LAT (LAT),
      .OPC_W   (5),
      .CNT_W   (CW),
      .ALU_W   (12)
    ) u_dut (
      .clk        (clk),
      .clr        (clr[g]),
      .run        (run[g]),
      .opcode     (opc[g]),
      .PCout      (s[0]),
      .MARin      (s[1]),
      .IncPC      (s[2]),
      .Zin        (s[3]),
      .PCin       (s[4]),
      .Zlowout    (s[5]),
      .MDRRead    (s[6]),
      .MDRin      (s[7]),
      .MDRout     (s[8]),
      .IRin       (s[9]),
      .Gra        (s[10]),
      .Grb        (s[11]),
      .Rin_in     (s[12]),
      .Rout_in    (s[13]),
      .BAout      (s[14]),
      .Yin        (s[15]),
      .Cout       (s[16]),
      .RAMwrite   (s[17]),
      .ALUControl (alu),
      .instr_done (s[18]),
      .illegal    (s[19]),
      .retired    (r)
    );

    assign obs[g] = {alu, s};
    assign ret[g] = 16'(r);
  end

  function automatic int lat_of(input int g);
    return (g == 0) ? 1 : ((g == 1) ? 0 : 2);
  endfunction

  function automatic int mask_of(input int g);
    return (g == 1) ? 32'hF : 32'hFFFF;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic push(input int g, input logic [11:0] a, input logic [19:0] s);
    sb.push_back({a, s});
    if ((s & M_DONE) != 20'h0) exp_ret[g] = (exp_ret[g] + 1) & mask_of(g);
  endtask

  // Reference step sequence of one instruction, starting at its T0.
  task automatic push_instr(input int g, input logic [4:0] op);
    int L;
    L = lat_of(g);
    push(g, 12'h0, M_PCOUT | M_MARIN | M_INCPC | M_ZIN);
    push(g, 12'h0, M_ZLO | M_PCIN | M_RD | ((L == 0) ? M_MDRIN : 20'h0));
    for (int i = 0; i < L; i++) push(g, 12'h0, M_RD | ((i == L - 1) ? M_MDRIN : 20'h0));
    push(g, 12'h0, M_MDRO | M_IRIN);
    if (op != LD && op != LDI && op != ST) begin
      push(g, 12'h0, M_GRB | M_BAO | M_ILL);
      return;
    end
    push(g, 12'h0, M_GRB | M_BAO | M_YIN);
    push(g, 12'h001, M_COUT | M_ZIN);
    if (op == LDI) begin
      push(g, 12'h0, M_ZLO | M_GRA | M_RIN | M_DONE);
      return;
    end
    push(g, 12'h0, M_ZLO | M_MARIN);
    if (op == LD) begin
      push(g, 12'h0, M_RD | ((L == 0) ? M_MDRIN : 20'h0));
      for (int i = 0; i < L; i++) push(g, 12'h0, M_RD | ((i == L - 1) ? M_MDRIN : 20'h0));
      push(g, 12'h0, M_MDRO | M_GRA | M_RIN | M_DONE);
    end else begin
      push(g, 12'h0, M_GRA | M_ROUT | M_MDRIN);
      for (int i = 0; i <= L; i++) push(g, 12'h0, M_RAMW | ((i == L) ? M_DONE : 20'h0));
    end
  endtask

  task automatic play(input int g, input int drop_at, input int chg_at, input logic [4:0] chg_val);
    int n;
    logic [31:0] e;
    n = 0;
    while (sb.size() > 0) begin
      @(negedge clk);
      n++;
      e = sb.pop_front();
      chk($sformatf("dut%0d_cyc%0d", g, n), obs[g], e);
      if (n == drop_at) run[g] = 1'b0;
      if (n == chg_at) opc[g] = chg_val;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    for (int g = 0; g < N; g++) begin
      clr[g] = 1'b1;
      run[g] = 1'b0;
      opc[g] = 5'd0;
      exp_ret[g] = 0;
    end
    #3;
    for (int g = 0; g < N; g++) begin
      chk($sformatf("rst_out%0d", g), obs[g], 32'h0);
      chk($sformatf("rst_ret%0d", g), {16'h0, ret[g]}, 32'h0);
    end
    @(negedge clk);
    for (int g = 0; g < N; g++) clr[g] = 1'b0;

    // MEM_LAT=1 ld; opcode switched after T3 must be ignored
    opc[0] = LD;
    run[0] = 1'b1;
    push_instr(0, LD);
    push(0, 12'h0, 20'h0);
    play(0, 1, 6, ST);
    chk("ld_ret", {16'h0, ret[0]}, 32'(exp_ret[0]));

    // MEM_LAT=0 ld then st back-to-back
    opc[1] = LD;
    run[1] = 1'b1;
    push_instr(1, LD);
    push_instr(1, ST);
    push(1, 12'h0, 20'h0);
    play(1, 9, 9, ST);
    chk("ldst_ret", {16'h0, ret[1]}, 32'(exp_ret[1]));

    // MEM_LAT=2 illegal opcode followed directly by ldi
    opc[2] = 5'b10101;
    run[2] = 1'b1;
    push_instr(2, 5'b10101);
    push_instr(2, LDI);
    push(2, 12'h0, 20'h0);
    play(2, 7, 6, LDI);
    chk("ill_ret", {16'h0, ret[2]}, 32'(exp_ret[2]));

    // Asynchronous clear in the middle of T4
    opc[0] = LD;
    run[0] = 1'b1;
    repeat (6) @(negedge clk);
    chk("pre_clr_t4", obs[0], {12'h001, M_COUT | M_ZIN});
    #2 clr[0] = 1'b1;
    #1;
    chk("clr_out", obs[0], 32'h0);
    chk("clr_ret", {16'h0, ret[0]}, 32'h0);
    exp_ret[0] = 0;
    #1 clr[0] = 1'b0;
    push_instr(0, LD);
    push(0, 12'h0, 20'h0);
    play(0, 1, 0, LD);
    chk("restart_ret", {16'h0, ret[0]}, 32'(exp_ret[0]));

    // CNT_W=4 wrap over 16 ldi instructions
    @(negedge clk);
    clr[1] = 1'b1;
    #1 clr[1] = 1'b0;
    exp_ret[1] = 0;
    for (int k = 1; k <= 16; k++) begin
      opc[1] = LDI;
      run[1] = 1'b1;
      push_instr(1, LDI);
      push(1, 12'h0, 20'h0);
      play(1, 1, 0, LDI);
      chk($sformatf("wrap_ret%0d", k), {16'h0, ret[1]}, 32'(exp_ret[1]));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
